float_accumulator_bf16: RTL

//  Sequential bf16 accumulator, directly downstream of the bf16 multiplier.

---
 rtl/float_accumulator_bf16_pkg.sv | 40 ++++
 rtl/bf16_align_shift.sv | 27 ++
 rtl/float_accumulator_bf16.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/float_accumulator_bf16_pkg.sv
// Shared definitions for the bf16 accumulator: format widths, special
// encodings, FSM state encoding and operand classification helpers.
package float_accumulator_bf16_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 7;
  localparam int BIAS    = 127;
  localparam int BF16_W  = 1 + EXP_W + MAN_W;
  // Aligned mantissa: hidden bit, stored mantissa, guard, round, sticky.
  localparam int ALIGN_W = MAN_W + 4;
  localparam int SHAMT_W = 5;
  // Signed internal exponent, wide enough to see both overflow and underflow.
  localparam int EXP_IW  = 10;

  localparam logic [BF16_W-1:0] BF16_QNAN = 16'h7FC0;
  localparam logic [BF16_W-1:0] BF16_PINF = 16'h7F80;
  localparam logic [BF16_W-1:0] BF16_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4
  } state_t;

  function automatic logic is_nan(input logic [BF16_W-1:0] v);
    return (v[BF16_W-2:MAN_W] == '1) && (v[MAN_W-1:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [BF16_W-1:0] v);
    return (v[BF16_W-2:MAN_W] == '1) && (v[MAN_W-1:0] == '0);
  endfunction

  // Exponent zero covers both true zeros and flushed subnormals.
  function automatic logic is_zero(input logic [BF16_W-1:0] v);
    return v[BF16_W-2:MAN_W] == '0;
  endfunction

endpackage

// File: rtl/bf16_align_shift.sv
// Combinational right shifter for mantissa alignment. Every bit shifted out
// is ORed into the least significant (sticky) bit of the result.
module bf16_align_shift
  import float_accumulator_bf16_pkg::*;
(
  input  logic [ALIGN_W-1:0] data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [ALIGN_W-1:0] data_out
);

  logic [ALIGN_W-1:0] lost_mask;
  logic [ALIGN_W-1:0] shifted;
  logic               sticky;

  // Bit gi is lost when the shift amount exceeds its position.
  genvar gi;
  generate
    for (gi = 0; gi < ALIGN_W; gi++) begin : g_lost_mask
      assign lost_mask[gi] = (SHAMT_W'(gi) < shamt);
    end
  endgenerate

  assign shifted  = data_in >> shamt;
  assign sticky   = |(data_in & lost_mask);
  assign data_out = {shifted[ALIGN_W-1:1], shifted[0] | sticky};

endmodule

// File: rtl/float_accumulator_bf16.sv
// Sequential bf16 accumulator: takes one product per handshake and adds it
// into the running sum with an align/add/normalise/round FSM (RNE).
module float_accumulator_bf16
  import float_accumulator_bf16_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [BF16_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [BF16_W-1:0] acc_out,
  output logic              out_valid,
  output logic              busy
);

  state_t state_reg;
  state_t state_next;

  logic [BF16_W-1:0]        acc_reg;
  logic [BF16_W-1:0]        op_reg;
  logic                     use_zero_reg;
  logic                     last_reg;
  logic                     out_valid_reg;
  // ALIGN takes two cycles: compare/unpack first, shift second.
  logic                     align_phase_reg;
  logic                     sign_reg;
  logic                     sub_reg;
  logic signed [EXP_IW-1:0] exp_reg;
  logic [ALIGN_W-1:0]       big_mant_reg;
  logic [ALIGN_W-1:0]       small_mant_reg;
  logic [ALIGN_W-1:0]       mant_reg;
  logic [SHAMT_W-1:0]       shamt_reg;
  logic                     bypass_reg;
  logic [BF16_W-1:0]        bypass_val_reg;

  // Operand ordering and classification.
  logic [BF16_W-1:0]        opa;
  logic [BF16_W-1:0]        opb;
  logic                     a_ge_b;
  logic [BF16_W-1:0]        big_op;
  logic [BF16_W-1:0]        small_op;
  logic [EXP_W:0]           exp_diff;
  logic [SHAMT_W-1:0]       shamt_sat;
  logic                     bypass_hit;
  logic [BF16_W-1:0]        bypass_val;
  logic [ALIGN_W-1:0]       shifted_mant;

  // Add stage.
  logic [ALIGN_W:0]         sum_raw;
  logic [ALIGN_W-1:0]       add_mant;
  logic signed [EXP_IW-1:0] add_exp;
  logic                     add_zero;

  // Round stage.
  logic                     round_up;
  logic [MAN_W:0]           frac_sum;
  logic signed [EXP_IW-1:0] rnd_exp;
  logic [BF16_W-1:0]        round_result;

  // A clear accompanying the term replaces the old sum with +0.
  assign opa      = use_zero_reg ? BF16_ZERO : acc_reg;
  assign opb      = op_reg;
  assign a_ge_b   = opa[BF16_W-2:0] >= opb[BF16_W-2:0];
  assign big_op   = a_ge_b ? opa : opb;
  assign small_op = a_ge_b ? opb : opa;
  assign exp_diff = {1'b0, big_op[BF16_W-2:MAN_W]} - {1'b0, small_op[BF16_W-2:MAN_W]};
  // Any difference of 11 or more already collapses into the sticky bit.
  assign shamt_sat = (exp_diff > (EXP_W+1)'(31)) ? SHAMT_W'(31) : exp_diff[SHAMT_W-1:0];

  bf16_align_shift u_align_shift (
    .data_in  (small_mant_reg),
    .shamt    (shamt_reg),
    .data_out (shifted_mant)
  );

  // Specials and zero operands resolve without going through the adder.
  always_comb begin
    bypass_hit = 1'b1;
    bypass_val = BF16_ZERO;
    if (is_nan(opa) || is_nan(opb) ||
        (is_inf(opa) && is_inf(opb) && (opa[BF16_W-1] != opb[BF16_W-1]))) begin
      bypass_val = BF16_QNAN;
    end else if (is_inf(opa)) begin
      bypass_val = opa;
    end else if (is_inf(opb)) begin
      bypass_val = opb;
    end else if (is_zero(opa) && is_zero(opb)) begin
      bypass_val = {opa[BF16_W-1] & opb[BF16_W-1], {(BF16_W-1){1'b0}}};
    end else if (is_zero(opa)) begin
      bypass_val = opb;
    end else if (is_zero(opb)) begin
      bypass_val = opa;
    end else begin
      bypass_hit = 1'b0;
    end
  end

  // Magnitude add/subtract; a carry out is folded back by one right shift.
  always_comb begin
    sum_raw  = sub_reg ? ({1'b0, big_mant_reg} - {1'b0, small_mant_reg})
                       : ({1'b0, big_mant_reg} + {1'b0, small_mant_reg});
    add_mant = sum_raw[ALIGN_W-1:0];
    add_exp  = exp_reg;
    add_zero = (sum_raw == '0);
    if (sum_raw[ALIGN_W]) begin
      add_mant = {sum_raw[ALIGN_W:2], sum_raw[1] | sum_raw[0]};
      add_exp  = exp_reg + EXP_IW'(1);
    end
  end

  // Round to nearest even, then saturate to infinity or flush to zero.
  always_comb begin
    round_up = mant_reg[2] & (mant_reg[1] | mant_reg[0] | mant_reg[3]);
    frac_sum = {1'b0, mant_reg[ALIGN_W-2:3]} + (MAN_W+1)'(round_up);
    rnd_exp  = exp_reg + $signed({{(EXP_IW-1){1'b0}}, frac_sum[MAN_W]});
    if (bypass_reg) begin
      round_result = bypass_val_reg;
    end else if (!mant_reg[ALIGN_W-1]) begin
      // Only an exactly cancelled sum arrives here without its hidden bit.
      round_result = BF16_ZERO;
    end else if (exp_reg <= 0) begin
      round_result = {sign_reg, {(BF16_W-1){1'b0}}};
    end else if (rnd_exp >= EXP_IW'(255)) begin
      round_result = {sign_reg, BF16_PINF[BF16_W-2:0]};
    end else begin
      round_result = {sign_reg, rnd_exp[EXP_W-1:0], frac_sum[MAN_W-1:0]};
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (align_phase_reg) state_next = ST_ADD;
      end
      ST_ADD: begin
        if (bypass_reg || add_zero || add_mant[ALIGN_W-1]) state_next = ST_ROUND;
        else state_next = ST_NORM;
      end
      ST_NORM: begin
        if (mant_reg[ALIGN_W-2]) state_next = ST_ROUND;
      end
      ST_ROUND: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath registers, advanced by the current FSM state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_reg         <= BF16_ZERO;
      op_reg          <= '0;
      use_zero_reg    <= 1'b0;
      last_reg        <= 1'b0;
      out_valid_reg   <= 1'b0;
      align_phase_reg <= 1'b0;
      sign_reg        <= 1'b0;
      sub_reg         <= 1'b0;
      exp_reg         <= '0;
      big_mant_reg    <= '0;
      small_mant_reg  <= '0;
      mant_reg        <= '0;
      shamt_reg       <= '0;
      bypass_reg      <= 1'b0;
      bypass_val_reg  <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            op_reg          <= in_data;
            last_reg        <= in_last;
            use_zero_reg    <= clear;
            align_phase_reg <= 1'b0;
          end else if (clear) begin
            acc_reg <= BF16_ZERO;
          end
        end
        ST_ALIGN: begin
          if (!align_phase_reg) begin
            align_phase_reg <= 1'b1;
            sign_reg        <= big_op[BF16_W-1];
            sub_reg         <= big_op[BF16_W-1] ^ small_op[BF16_W-1];
            exp_reg         <= $signed({2'b00, big_op[BF16_W-2:MAN_W]});
            big_mant_reg    <= {1'b1, big_op[MAN_W-1:0], 3'b000};
            small_mant_reg  <= {1'b1, small_op[MAN_W-1:0], 3'b000};
            shamt_reg       <= shamt_sat;
            bypass_reg      <= bypass_hit;
            bypass_val_reg  <= bypass_val;
          end else begin
            small_mant_reg  <= shifted_mant;
          end
        end
        ST_ADD: begin
          mant_reg <= add_mant;
          exp_reg  <= add_exp;
        end
        ST_NORM: begin
          mant_reg <= {mant_reg[ALIGN_W-2:0], 1'b0};
          exp_reg  <= exp_reg - EXP_IW'(1);
        end
        ST_ROUND: begin
          acc_reg         <= round_result;
          out_valid_reg   <= last_reg;
          align_phase_reg <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign acc_out   = acc_reg;
  assign out_valid = out_valid_reg;

endmodule
